win_scanner: RTL and testbench

- Reads the 6x7 token ownership board produced by the move-commit logic and decides whether the last committed move ended the game.
- Each `start` snapshots the board, then walks every cell as a line anchor, one per cycle, checking four directions for WIN_LEN same-owner tokens.
- Reports winner, draw, or no result, plus the winning line's anchor and direction, to the game controller and display.

---
 rtl/win_scanner.sv | 173 +++++++++++++++++
 tb/tb_win_scanner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/win_scanner.sv
// Connect-four style win detector: snapshots the token board on start and walks
// every cell as a line anchor, one per cycle, reporting winner/draw and the winning line.
module win_scanner #(
  parameter int unsigned ROWS    = 6,
  parameter int unsigned COLS    = 7,
  parameter int unsigned WIN_LEN = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            newGame,
  input  logic                            start,
  input  logic [ROWS-1:0][COLS-1:0][1:0]  tokens,
  output logic                            busy,
  output logic                            done,
  output logic [1:0]                      winner,
  output logic [$clog2(ROWS)-1:0]         win_row,
  output logic [$clog2(COLS)-1:0]         win_col,
  output logic [1:0]                      win_dir
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int          RI = int'(ROWS);
  localparam int          CI = int'(COLS);
  localparam int          WL = int'(WIN_LEN);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                         state, state_d;
  logic [ROWS-1:0][COLS-1:0][1:0] snap, snap_d;
  logic [RW-1:0]                  row_q, row_d;
  logic [CW-1:0]                  col_q, col_d;
  logic                           prime_q, prime_d;
  logic                           busy_d, done_d;
  logic [1:0]                     winner_d, win_dir_d;
  logic [RW-1:0]                  win_row_d;
  logic [CW-1:0]                  win_col_d;
  logic [ROWS-1:0][COLS-1:0][3:0] line_win;
  logic [3:0]                     sel_win;
  logic                           full;
  logic                           last_anchor;

  // Per-anchor, per-direction line detectors; lines leaving the board are tied off.
  for (genvar r = 0; r < RI; r++) begin : g_row
    for (genvar c = 0; c < CI; c++) begin : g_col
      for (genvar d = 0; d < 4; d++) begin : g_dir
        localparam int DR = (d == 0) ? 0 : 1;
        localparam int DC = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
        localparam int ER = r + (WL - 1) * DR;
        localparam int EC = c + (WL - 1) * DC;
        if (ER < RI && EC >= 0 && EC < CI) begin : g_fit
          logic [WIN_LEN-1:0] same;
          for (genvar i = 0; i < WL; i++) begin : g_cell
            assign same[i] = (snap[r + i * DR][c + i * DC] == snap[r][c]);
          end
          assign line_win[r][c][d] = (&same) &&
                                     (snap[r][c] == 2'b01 || snap[r][c] == 2'b10);
        end else begin : g_off
          assign line_win[r][c][d] = 1'b0;
        end
      end
    end
  end

  // Draw needs every cell owned by a player; unowned (11) cells block it.
  always_comb begin
    full = 1'b1;
    for (int r = 0; r < RI; r++) begin
      for (int c = 0; c < CI; c++) begin
        if (snap[r][c] == 2'b00 || snap[r][c] == 2'b11) full = 1'b0;
      end
    end
  end

  assign sel_win     = line_win[row_q][col_q];
  assign last_anchor = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));

  // Next-state and registered-output logic; prime_q burns the first SCAN cycle.
  always_comb begin
    state_d   = state;
    snap_d    = snap;
    row_d     = row_q;
    col_d     = col_q;
    prime_d   = prime_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    winner_d  = winner;
    win_row_d = win_row;
    win_col_d = win_col;
    win_dir_d = win_dir;
    case (state)
      IDLE: begin
        if (start) begin
          snap_d    = tokens;
          row_d     = '0;
          col_d     = '0;
          prime_d   = 1'b1;
          winner_d  = 2'b00;
          win_row_d = '0;
          win_col_d = '0;
          win_dir_d = 2'b00;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (prime_q) begin
          prime_d = 1'b0;
          busy_d  = 1'b1;
        end else if (|sel_win) begin
          winner_d  = snap[row_q][col_q];
          win_row_d = row_q;
          win_col_d = col_q;
          if (sel_win[0])      win_dir_d = 2'b00;
          else if (sel_win[1]) win_dir_d = 2'b01;
          else if (sel_win[2]) win_dir_d = 2'b10;
          else                 win_dir_d = 2'b11;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (last_anchor) begin
          winner_d  = full ? 2'b11 : 2'b00;
          win_row_d = '0;
          win_col_d = '0;
          win_dir_d = 2'b00;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          busy_d = 1'b1;
          if (col_q == CW'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || newGame) begin
      state   <= IDLE;
      snap    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      prime_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      winner  <= 2'b00;
      win_row <= '0;
      win_col <= '0;
      win_dir <= 2'b00;
    end else begin
      state   <= state_d;
      snap    <= snap_d;
      row_q   <= row_d;
      col_q   <= col_d;
      prime_q <= prime_d;
      busy    <= busy_d;
      done    <= done_d;
      winner  <= winner_d;
      win_row <= win_row_d;
      win_col <= win_col_d;
      win_dir <= win_dir_d;
    end
  end

endmodule

// File: tb/tb_win_scanner.sv
// Directed bench for win_scanner: hand-built boards with hand-computed latency and result.
module tb_win_scanner;

  localparam int unsigned ROWS    = 6;
  localparam int unsigned COLS    = 7;
  localparam int unsigned WIN_LEN = 4;

  logic                           clock = 1'b0;
  logic                           reset;
  logic                           newGame;
  logic                           start;
  logic [ROWS-1:0][COLS-1:0][1:0] tokens;
  logic                           busy;
  logic                           done;
  logic [1:0]                     winner;
  logic [2:0]                     win_row;
  logic [2:0]                     win_col;
  logic [1:0]                     win_dir;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  win_scanner #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) dut (
    .clock   (clock),
    .reset   (reset),
    .newGame (newGame),
    .start   (start),
    .tokens  (tokens),
    .busy    (busy),
    .done    (done),
    .winner  (winner),
    .win_row (win_row),
    .win_col (win_col),
    .win_dir (win_dir)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ":busy"},    32'(busy),    0);
    chk({tag, ":done"},    32'(done),    0);
    chk({tag, ":winner"},  32'(winner),  0);
    chk({tag, ":win_row"}, 32'(win_row), 0);
    chk({tag, ":win_col"}, 32'(win_col), 0);
    chk({tag, ":win_dir"}, 32'(win_dir), 0);
  endtask

  // Rows alternate the phase of 2-wide column pairs: full board, no line of four anywhere.
  task automatic draw_board();
    for (int r = 0; r < int'(ROWS); r++)
      for (int c = 0; c < int'(COLS); c++)
        tokens[r][c] = ((((c / 2) + r) % 2) == 0) ? 2'b01 : 2'b10;
  endtask

  // act 1: pulse start at lat==mid; act 2: rewrite tokens to a winning board at lat==mid.
  task automatic do_scan(input string tag, input int exp_lat, input logic [1:0] ew,
                         input int er, input int ec, input logic [1:0] ed,
                         input int mid, input int act);
    int lat;
    int bcnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ":clr"}, 32'(winner), 0);
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      start = (act == 1 && lat == mid);
      if (act == 2 && lat == mid)
        for (int c = 0; c < 4; c++) tokens[ROWS-1][c] = 2'b01;
      tick();
      lat++;
    end
    start = 1'b0;
    chk({tag, ":lat"},     32'(lat),     32'(exp_lat));
    chk({tag, ":winner"},  32'(winner),  32'(ew));
    chk({tag, ":win_row"}, 32'(win_row), 32'(er));
    chk({tag, ":win_col"}, 32'(win_col), 32'(ec));
    chk({tag, ":win_dir"}, 32'(win_dir), 32'(ed));
    chk({tag, ":busy_at_done"}, 32'(busy), 0);
    chk({tag, ":busy_cycles"},  32'(bcnt), 32'(exp_lat - 1));
    tick();
    chk({tag, ":done_pulse"},  32'(done),   0);
    chk({tag, ":winner_hold"}, 32'(winner), 32'(ew));
  endtask

  initial begin
    int seen;
    int lat;
    reset   = 1'b1;
    newGame = 1'b0;
    start   = 1'b0;
    tokens  = '0;
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();

    do_scan("empty", 43, 2'b00, 0, 0, 2'b00, -1, 0);

    tokens = '0;
    for (int c = 0; c < 4; c++) tokens[5][c] = 2'b01;
    do_scan("row5", 37, 2'b01, 5, 0, 2'b00, -1, 0);

    tokens = '0;
    for (int r = 2; r < 6; r++) tokens[r][6] = 2'b10;
    tokens[5][0] = 2'b01;
    tokens[5][1] = 2'b01;
    tokens[4][0] = 2'b01;
    do_scan("col6", 22, 2'b10, 2, 6, 2'b01, -1, 0);

    tokens = '0;
    tokens[2][3] = 2'b01;
    tokens[3][2] = 2'b01;
    tokens[4][1] = 2'b01;
    tokens[5][0] = 2'b01;
    do_scan("diag_dl", 19, 2'b01, 2, 3, 2'b11, -1, 0);

    tokens = '0;
    for (int i = 0; i < 4; i++) begin
      tokens[0][i] = 2'b01;
      tokens[i][0] = 2'b01;
    end
    do_scan("prio_hv", 2, 2'b01, 0, 0, 2'b00, -1, 0);

    tokens = '0;
    for (int i = 0; i < 4; i++) begin
      tokens[i][0] = 2'b10;
      tokens[i][i] = 2'b10;
    end
    do_scan("prio_vd", 2, 2'b10, 0, 0, 2'b01, -1, 0);

    tokens = '0;
    for (int c = 3; c < 7; c++) tokens[5][c] = 2'b01;
    do_scan("row5_end", 40, 2'b01, 5, 3, 2'b00, -1, 0);

    draw_board();
    do_scan("draw", 43, 2'b11, 0, 0, 2'b00, -1, 0);

    draw_board();
    for (int c = 0; c < 4; c++) tokens[0][c] = 2'b11;
    do_scan("unowned", 43, 2'b00, 0, 0, 2'b00, -1, 0);

    tokens = '0;
    do_scan("mid_start", 43, 2'b00, 0, 0, 2'b00, 5, 1);
    seen = 0;
    repeat (50) begin
      if (done === 1'b1) seen++;
      tick();
    end
    chk("mid_start:extra_done", 32'(seen), 0);

    tokens = '0;
    do_scan("snapshot", 43, 2'b00, 0, 0, 2'b00, 3, 2);

    // tokens now hold the row-5 win; a fresh scan sees it, then newGame clears held results.
    do_scan("pre_ng", 37, 2'b01, 5, 0, 2'b00, -1, 0);
    newGame = 1'b1;
    tick();
    newGame = 1'b0;
    chk_zero("ng_idle");

    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("ng_scan:busy_before", 32'(busy), 1);
    newGame = 1'b1;
    tick();
    newGame = 1'b0;
    chk_zero("ng_scan");
    seen = 0;
    repeat (50) begin
      if (done === 1'b1) seen++;
      tick();
    end
    chk("ng_scan:no_done", 32'(seen), 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    chk("rst_done:lat", 32'(lat), 37);
    chk("rst_done:winner_before", 32'(winner), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero("rst_done");
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
